lsu_sequencer: RTL and testbench

LSU_SEQUENCER -- requirements
Module: lsu_sequencer

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_lane_extend.sv | 41 ++++
 rtl/lsu_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_lsu_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store sequencer: request size encodings,
// FSM state type and the default ACCESS timeout.
package lsu_pkg;

   localparam int unsigned TIMEOUT_DEFAULT = 255;

   // req_sel encodings; 101..111 are treated as a full word
   localparam logic [2:0] SEL_B  = 3'b000;
   localparam logic [2:0] SEL_H  = 3'b001;
   localparam logic [2:0] SEL_W  = 3'b010;
   localparam logic [2:0] SEL_BU = 3'b011;
   localparam logic [2:0] SEL_HU = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } lsu_size_e;

   // Collapse the signed/unsigned variants onto an access width.
   function automatic lsu_size_e sel_size(input logic [2:0] sel);
      case (sel)
         SEL_B, SEL_BU: sel_size = SZ_BYTE;
         SEL_H, SEL_HU: sel_size = SZ_HALF;
         default:       sel_size = SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_extend.sv
// Load data lane select and sign/zero extension. Purely combinational:
// picks the addressed byte or halfword out of the returned memory word and
// extends it to 32 bits according to the request size selector.
module lsu_lane_extend
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  sel,
   output logic [31:0] ext_data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Lane extraction; halfwords only look at addr_lo[1] (addr_lo[0] truncated)
   always_comb begin
      byte_lane = rdata[7:0];
      case (addr_lo)
         2'd0: byte_lane = rdata[7:0];
         2'd1: byte_lane = rdata[15:8];
         2'd2: byte_lane = rdata[23:16];
         2'd3: byte_lane = rdata[31:24];
         default: byte_lane = rdata[7:0];
      endcase
      half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
   end

   // Extension by selector; unknown selectors behave as a word load
   always_comb begin
      ext_data = rdata;
      case (sel)
         SEL_B:   ext_data = {{24{byte_lane[7]}}, byte_lane};
         SEL_BU:  ext_data = {24'h0, byte_lane};
         SEL_H:   ext_data = {{16{half_lane[15]}}, half_lane};
         SEL_HU:  ext_data = {16'h0, half_lane};
         default: ext_data = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_sequencer.sv
// Single-outstanding load/store sequencer between a core request port and a
// word-wide memory port. Accepts one request in IDLE, holds a memory access
// until mem_ack or timeout, then returns a one-cycle response.
// Optional build macro: LSU_MISALIGN_TRAP_EN -- misaligned half/word requests
// skip the memory access and respond immediately with rsp_err.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | req_ready high, waiting for req_valid
// ST_ACCESS | mem_req held with captured fields, counting wait cycles
// ST_RESP   | rsp_valid high for one cycle with captured data/error
module lsu_sequencer
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_sel,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   // Wait count value on the last ACCESS cycle before a timeout is declared
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   lsu_state_e  state, state_nxt;
   logic        accept;
   logic        ack_take;
   logic        timeout;
   logic        misalign_trap;

   logic [7:0]  wait_cnt;
   logic        cap_we;
   logic [2:0]  cap_sel;
   logic [1:0]  cap_addr_lo;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic [31:0] fmt_wdata;
   logic [3:0]  fmt_be;
   logic [31:0] ext_data;

`ifdef LSU_MISALIGN_TRAP_EN
   // Misaligned half/word requests are trapped at accept time
   always_comb begin
      misalign_trap = 1'b0;
      case (sel_size(req_sel))
         SZ_HALF: misalign_trap = req_addr[0];
         SZ_WORD: misalign_trap = |req_addr[1:0];
         default: misalign_trap = 1'b0;
      endcase
   end
`else
   assign misalign_trap = 1'b0;
`endif

   // Store data replication and byte enables; loads always read the full word
   always_comb begin
      fmt_wdata = 32'h0;
      fmt_be    = 4'b1111;
      if (req_we) begin
         case (sel_size(req_sel))
            SZ_BYTE: begin
               fmt_wdata = {4{req_wdata[7:0]}};
               fmt_be    = 4'b0001 << req_addr[1:0];
            end
            SZ_HALF: begin
               fmt_wdata = {2{req_wdata[15:0]}};
               fmt_be    = 4'b0011 << {req_addr[1], 1'b0};
            end
            default: begin
               fmt_wdata = req_wdata;
               fmt_be    = 4'b1111;
            end
         endcase
      end
   end

   lsu_lane_extend u_lane_extend (
      .rdata    (mem_rdata),
      .addr_lo  (cap_addr_lo),
      .sel      (cap_sel),
      .ext_data (ext_data)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode; an ack in the timeout cycle takes priority
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      ack_take  = 1'b0;
      timeout   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = misalign_trap ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (mem_ack) begin
               ack_take  = 1'b1;
               state_nxt = ST_RESP;
            end else if (wait_cnt == TIMEOUT_LAST) begin
               timeout   = 1'b1;
               state_nxt = ST_RESP;
            end
         end
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Request capture, wait counter and response data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt    <= 8'h0;
         cap_we      <= 1'b0;
         cap_sel     <= 3'h0;
         cap_addr_lo <= 2'h0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         be_q        <= 4'h0;
         rdata_q     <= 32'h0;
         err_q       <= 1'b0;
      end else begin
         if (accept) begin
            wait_cnt    <= 8'h0;
            cap_we      <= req_we;
            cap_sel     <= req_sel;
            cap_addr_lo <= req_addr[1:0];
            addr_q      <= {req_addr[31:2], 2'b00};
            wdata_q     <= fmt_wdata;
            be_q        <= fmt_be;
            rdata_q     <= 32'h0;
            err_q       <= misalign_trap;
         end else if (ack_take) begin
            rdata_q     <= cap_we ? 32'h0 : ext_data;
            err_q       <= 1'b0;
         end else if (timeout) begin
            rdata_q     <= 32'h0;
            err_q       <= 1'b1;
         end else if (state == ST_ACCESS) begin
            wait_cnt    <= wait_cnt + 8'd1;
         end
      end
   end

   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign mem_req   = (state == ST_ACCESS);
   assign mem_we    = (state == ST_ACCESS) && cap_we;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer with TIMEOUT_CYCLES = 4. Works in both
// builds; the misaligned vectors pick their expectation from
// LSU_MISALIGN_TRAP_EN.
module tb_lsu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_sel;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int n_vec  = 0;
   int n_miss = 0;

   lsu_sequencer #(.TIMEOUT_CYCLES(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_sel   (req_sel),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Starts and ends on a falling edge with the DUT in IDLE. ack_at is the
   // ACCESS cycle (1-based) carrying mem_ack, 0 for never. exp_lat counts
   // rising edges from accept to the first rsp_valid sample.
   task automatic run_txn(input string tag, input logic we, input logic [2:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ack_at,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input logic [3:0] exp_be, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_lat);
      int lat;
      chk({tag, ":ready_idle"}, req_ready, 1'b1);
      req_valid = 1'b1;
      req_we    = we;
      req_sel   = sel;
      req_addr  = addr;
      req_wdata = wdata;
      mem_rdata = rdata;
      mem_ack   = (ack_at == 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we    = ~we;
      req_sel   = 3'b101;
      req_addr  = ~addr;
      req_wdata = ~wdata;
      lat = 1;
      @(negedge clk);
      while (!rsp_valid && lat < 300) begin
         chk({tag, ":ready_busy"}, req_ready, 1'b0);
         chk({tag, ":mem_req"}, mem_req, 1'b1);
         if (lat == 1) begin
            chk({tag, ":mem_addr"}, mem_addr, exp_addr);
            chk({tag, ":mem_we"}, mem_we, we);
            chk({tag, ":mem_be"}, mem_be, exp_be);
            if (we) chk({tag, ":mem_wdata"}, mem_wdata, exp_wdata);
         end
         mem_ack = (lat == ack_at);
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         lat++;
         @(negedge clk);
      end
      mem_ack = 1'b0;
      chk({tag, ":rsp_valid"}, rsp_valid, 1'b1);
      chk({tag, ":latency"}, lat, exp_lat);
      chk({tag, ":rsp_rdata"}, rsp_rdata, exp_rdata);
      chk({tag, ":rsp_err"}, rsp_err, exp_err);
      chk({tag, ":mem_req_resp"}, mem_req, 1'b0);
      @(negedge clk);
      chk({tag, ":rsp_one_cycle"}, rsp_valid, 1'b0);
      chk({tag, ":ready_after"}, req_ready, 1'b1);
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_sel   = 3'b000;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;

      @(negedge clk);
      chk("rst:req_ready", req_ready, 1'b1);
      chk("rst:rsp_valid", rsp_valid, 1'b0);
      chk("rst:rsp_rdata", rsp_rdata, 32'h0);
      chk("rst:rsp_err",   rsp_err, 1'b0);
      chk("rst:mem_req",   mem_req, 1'b0);
      chk("rst:mem_we",    mem_we, 1'b0);
      chk("rst:mem_addr",  mem_addr, 32'h0);
      chk("rst:mem_wdata", mem_wdata, 32'h0);
      chk("rst:mem_be",    mem_be, 4'h0);
      reset = 1'b0;
      @(negedge clk);

      //       tag    we    sel     addr          wdata         rdata         ack  exp_addr      exp_wdata     be       exp_rdata     err  lat
      run_txn("lb",   1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1, 32'h0000_0100, 32'h0,        4'b1111, 32'hFFFF_FF80, 1'b0, 2);
      run_txn("lhu",  1'b0, 3'b100, 32'h0000_0102, 32'h0,        32'hBEEF_0000, 1, 32'h0000_0100, 32'h0,        4'b1111, 32'h0000_BEEF, 1'b0, 2);
      run_txn("sb",   1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'hDEAD_BEEF, 1, 32'h0000_0200, 32'hABAB_ABAB, 4'b0010, 32'h0,        1'b0, 2);
      run_txn("lw_to",1'b0, 3'b010, 32'h0000_0300, 32'h0,        32'h1234_5678, 0, 32'h0000_0300, 32'h0,        4'b1111, 32'h0,        1'b1, 5);
      run_txn("lw_a4",1'b0, 3'b010, 32'h0000_0300, 32'h0,        32'h1234_5678, 4, 32'h0000_0300, 32'h0,        4'b1111, 32'h1234_5678, 1'b0, 5);
      run_txn("lh",   1'b0, 3'b001, 32'h0000_0106, 32'h0,        32'h8001_7FFF, 2, 32'h0000_0104, 32'h0,        4'b1111, 32'hFFFF_8001, 1'b0, 3);
      run_txn("lbu",  1'b0, 3'b011, 32'h0000_0101, 32'h0,        32'h0000_9A00, 1, 32'h0000_0100, 32'h0,        4'b1111, 32'h0000_009A, 1'b0, 2);
      run_txn("sh",   1'b1, 3'b001, 32'h0000_0402, 32'h1234_CAFE, 32'h5555_5555, 1, 32'h0000_0400, 32'hCAFE_CAFE, 4'b1100, 32'h0,        1'b0, 2);
      run_txn("sw",   1'b1, 3'b010, 32'h0000_0500, 32'h1122_3344, 32'h5555_5555, 3, 32'h0000_0500, 32'h1122_3344, 4'b1111, 32'h0,        1'b0, 4);
      run_txn("sel7", 1'b0, 3'b111, 32'h0000_010C, 32'h0,        32'h8765_4321, 1, 32'h0000_010C, 32'h0,        4'b1111, 32'h8765_4321, 1'b0, 2);
`ifdef LSU_MISALIGN_TRAP_EN
      run_txn("lw_mis",1'b0,3'b010, 32'h0000_0102, 32'h0,        32'hCAFE_F00D, 1, 32'h0000_0100, 32'h0,        4'b1111, 32'h0,        1'b1, 1);
      run_txn("lh_mis",1'b0,3'b001, 32'h0000_0101, 32'h0,        32'h0000_8765, 1, 32'h0000_0100, 32'h0,        4'b1111, 32'h0,        1'b1, 1);
`else
      run_txn("lw_mis",1'b0,3'b010, 32'h0000_0102, 32'h0,        32'hCAFE_F00D, 1, 32'h0000_0100, 32'h0,        4'b1111, 32'hCAFE_F00D, 1'b0, 2);
      run_txn("lh_mis",1'b0,3'b001, 32'h0000_0101, 32'h0,        32'h0000_8765, 1, 32'h0000_0100, 32'h0,        4'b1111, 32'hFFFF_8765, 1'b0, 2);
`endif

      // Reset in the middle of an ACCESS: request must vanish without a response
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_sel   = 3'b010;
      req_addr  = 32'h0000_0700;
      mem_ack   = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("rstmid:mem_req_pre", mem_req, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk("rstmid:mem_req", mem_req, 1'b0);
      chk("rstmid:rsp_valid", rsp_valid, 1'b0);
      chk("rstmid:mem_addr", mem_addr, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rstmid:no_rsp", rsp_valid, 1'b0);
         chk("rstmid:ready", req_ready, 1'b1);
         chk("rstmid:idle_mem", mem_req, 1'b0);
      end

      run_txn("post", 1'b0, 3'b000, 32'h0000_0800, 32'h0,        32'h0000_007F, 1, 32'h0000_0800, 32'h0,        4'b1111, 32'h0000_007F, 1'b0, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
